// File: rtl/fpu_issue_stage.sv
// Issue/writeback stage in front of the fixed-point unit: request FIFO, IDLE/EXEC/WB sequencer, held writeback.
// Optional watchdog enabled by defining FPU_ISSUE_TIMEOUT_EN.
module fpu_issue_stage #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RD_WIDTH = 5,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_operation,
    input  logic [WIDTH-1:0]    in_operand_1,
    input  logic [WIDTH-1:0]    in_operand_2,
    input  logic [RD_WIDTH-1:0] in_rd,
    output logic [WIDTH-1:0]    fpu_operand_1,
    output logic [WIDTH-1:0]    fpu_operand_2,
    output logic [1:0]          fpu_operation,
    input  logic [WIDTH-1:0]    fpu_result,
    input  logic                fpu_ready,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [RD_WIDTH-1:0] wb_rd,
    output logic [WIDTH-1:0]    wb_result,
    output logic                wb_error
);

    localparam logic [1:0] FPU_ADD = 2'b00;

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned EXEC_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t state, state_next;

    logic [1:0]          mem_op [DEPTH];
    logic [WIDTH-1:0]    mem_a  [DEPTH];
    logic [WIDTH-1:0]    mem_b  [DEPTH];
    logic [RD_WIDTH-1:0] mem_rd [DEPTH];

    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [EXEC_W-1:0] exec_cnt;
    logic              push, pop, capture, timeout;

    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;
    assign wb_valid = (state == WB);
    // exec_cnt == 0 marks the settle cycle, where a combinational fpu_ready may still be stale
    assign capture  = (state == EXEC) && (exec_cnt != '0) && fpu_ready;
    assign pop      = capture || timeout;

`ifdef FPU_ISSUE_TIMEOUT_EN
    // Fires on the edge where exec_cnt would reach TIMEOUT, so EXEC lasts exactly TIMEOUT cycles
    assign timeout = (state == EXEC) && !capture && (exec_cnt == EXEC_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_error <= 1'b0;
        end else if (timeout) begin
            wb_error <= 1'b1;
        end else if (wb_valid && wb_ready) begin
            wb_error <= 1'b0;
        end
    end
`else
    assign timeout  = 1'b0;
    assign wb_error = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        fpu_operand_1 = '0;
        fpu_operand_2 = '0;
        fpu_operation = FPU_ADD;
        case (state)
            IDLE: if (count != '0) state_next = EXEC;
            EXEC: begin
                fpu_operand_1 = mem_a[rd_ptr];
                fpu_operand_2 = mem_b[rd_ptr];
                fpu_operation = mem_op[rd_ptr];
                if (pop) state_next = WB;
            end
            WB:      if (wb_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr] <= in_operation;
            mem_a[wr_ptr]  <= in_operand_1;
            mem_b[wr_ptr]  <= in_operand_2;
            mem_rd[wr_ptr] <= in_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            exec_cnt  <= '0;
            wb_result <= '0;
            wb_rd     <= '0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (state != EXEC) begin
                exec_cnt <= '0;
            end else if (exec_cnt != '1) begin
                exec_cnt <= exec_cnt + 1'b1;
            end
            if (capture) begin
                wb_result <= fpu_result;
                wb_rd     <= mem_rd[rd_ptr];
            end else if (timeout) begin
                wb_result <= '0;
                wb_rd     <= mem_rd[rd_ptr];
            end
        end
    end

endmodule

// File: doc/fpu_issue_stage.md
# fpu_issue_stage

Issue and writeback stage placed directly upstream of the fixed-point unit (ADD/SUB/MUL/SQRT). It buffers fixed-point requests from decode in a small FIFO. It drives one request at a time onto the fixed-point unit's operand/operation inputs, waits for that unit's `ready`, and captures the result into a writeback register that holds until the register-file port accepts it.

## Interface
- `WIDTH`, 32: operand/result width.
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `RD_WIDTH`, 5: destination register tag width.
- `TIMEOUT`, 64: watchdog limit in cycles; used only with `FPU_ISSUE_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: request present.
- `in_ready` out 1: FIFO can accept a request.
- `in_operation` in 2: `FPU_ADD/SUB/MUL/SQRT` code from `Defines.vh`.
- `in_operand_1`, `in_operand_2` in WIDTH: source operands.
- `in_rd` in RD_WIDTH: destination tag.
- `fpu_operand_1`, `fpu_operand_2` out WIDTH: to the fixed-point unit.
- `fpu_operation` out 2: to the fixed-point unit.
- `fpu_result` in WIDTH: from the fixed-point unit.
- `fpu_ready` in 1: from the fixed-point unit.
- `wb_valid` out 1: writeback result valid.
- `wb_ready` in 1: writeback port accepts.
- `wb_rd` out RD_WIDTH: destination tag of the result.
- `wb_result` out WIDTH: result value.
- `wb_error` out 1: watchdog abort flag; constant 0 without the macro.

## Operation
- FIFO:
  - Circular buffer with read/write pointers and a `count` of width clog2(DEPTH)+1.
  - `in_ready = (count != DEPTH)`, evaluated independently of a same-cycle pop.
  - Push on `in_valid && in_ready`. Pop happens on result capture.
  - Simultaneous push and pop leaves `count` unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, EXEC, WB.
  - IDLE: if `count != 0`, go to EXEC and clear `exec_cnt`.
  - EXEC:
    - `fpu_*` driven from the FIFO head entry.
    - `exec_cnt` increments, saturating.
    - The first EXEC cycle is a settle cycle: `fpu_ready` is ignored while `exec_cnt == 0`, because the fixed-point unit's ready is combinational and can be stale.
    - At a rising edge with `exec_cnt >= 1 && fpu_ready`:
      - `wb_result <= fpu_result` and `wb_rd <=` head `rd`.
      - Pop the head.
      - Go to WB.
  - WB:
    - `wb_valid = 1`.
    - `wb_result` and `wb_rd` stay stable until `wb_valid && wb_ready`, then go to IDLE.
- Outside EXEC, `fpu_operand_1/2 = 0` and `fpu_operation = FPU_ADD`.
- No arithmetic is performed on data; values pass through bit-exact.

## Timing
- Reset values: `in_ready=1`, `wb_valid=0`, `wb_result=0`, `wb_rd=0`, `wb_error=0`, `fpu_operand_*=0`, `fpu_operation=FPU_ADD`, FSM=IDLE, `count=0`.
- Reset asserted in any state, including mid-EXEC or WB:
  - All in-flight and queued requests are discarded.
  - The outputs above take their reset values at the next edge.
- Minimum latency with an empty FIFO and `fpu_ready` constantly 1:
  - Push at edge E0.
  - IDLE→EXEC at E1.
  - Settle cycle E1–E2.
  - Capture at E3.
  - `wb_valid` high from E3 to the accept edge.
  - Push-to-`wb_valid` is 3 cycles.
- Back-to-back throughput is one result per 4 cycles when `wb_ready=1`: EXEC 2, WB 1, IDLE 1.
- Multi-cycle ops: capture happens at the first edge after the settle cycle where `fpu_ready=1`. `fpu_*` stay stable for the entire EXEC.
- `wb_ready` held low: FSM remains in WB and the FIFO keeps accepting pushes until full.

## Configuration
- `FPU_ISSUE_TIMEOUT_EN` defined:
  - `exec_cnt` is compared against `TIMEOUT`.
  - If EXEC reaches `exec_cnt == TIMEOUT` without capture, the stage goes to WB with `wb_result = 0`, `wb_rd` = head `rd`, and `wb_error = 1`, and pops the head.
  - `wb_error` clears when the result is accepted.
- Macro undefined: no watchdog; EXEC waits indefinitely for `fpu_ready`, and `wb_error` is tied to 0.

## Test plan
- Single ADD: push op=`FPU_ADD`, op1=0x00000C00, op2=0x00000400, rd=3, with the FPU model returning the sum and ready=1. Expect `wb_valid` exactly 3 cycles after the push, `wb_result=0x00001000`, `wb_rd=3`.
- Multi-cycle MUL: FPU model raises `fpu_ready` 5 cycles after EXEC entry. Expect `fpu_*` stable for all EXEC cycles, one capture, and `wb_valid` one edge after ready is sampled.
- Fill/backpressure: hold `wb_ready=0` and push 5 requests with DEPTH=4. Expect `in_ready=0` once 4 are queued. After releasing `wb_ready`, expect results in push order with rd tags 0,1,2,3,4 and no loss across pointer wrap.
- Stale ready: keep `fpu_ready=1` constantly and queue SQRT after ADD. Expect each op to spend at least 2 EXEC cycles and the SQRT result to come from the SQRT cycle.
- Reset mid-EXEC with 3 entries queued: assert `reset` for 1 cycle. Expect `count=0`, `wb_valid=0`, `in_ready=1` after the next edge, and no writeback afterwards.
- With `FPU_ISSUE_TIMEOUT_EN` and TIMEOUT=8: keep `fpu_ready=0`. Expect `wb_valid=1`, `wb_error=1`, `wb_result=0` after 8 EXEC cycles, and the next queued request then executing normally.
